// File: rtl/reset_seq_pkg.sv
// Shared types and parameter legality bounds for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 8;
  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 4;
  localparam int FILT_MIN     = 1;
  localparam int HOLD_MIN     = 1;
  localparam int GAP_MIN      = 1;
  localparam int FAULT_CNT_W  = 8;

endpackage

// File: rtl/rst_sync_bit.sv
// One synchroniser chain with an optional "stable high for N cycles" qualifier.
module rst_sync_bit #(
  parameter int STAGES      = 2,
  parameter bit FILT_EN     = 1'b0,
  parameter int FILT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level
);

  logic [STAGES-1:0] r_chain;
  logic              w_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_chain <= '0;
    else            r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign w_sync = r_chain[STAGES-1];

  generate
    if (FILT_EN) begin : g_filt
      localparam int CW = $clog2(FILT_CYCLES + 1);
      logic [CW-1:0] r_cnt;

      // Saturating run-length of the synchronised high level; any low clears it.
      always_ff @(posedge i_clk) begin
        if (!i_reset_n)                  r_cnt <= '0;
        else if (!w_sync)                r_cnt <= '0;
        else if (r_cnt != CW'(FILT_CYCLES)) r_cnt <= r_cnt + CW'(1);
      end

      // Drops in the very cycle the synchronised input is low.
      assign o_level = w_sync && (r_cnt == CW'(FILT_CYCLES));
    end else begin : g_nofilt
      assign o_level = w_sync;
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: qualifies lock/external reset, holds, then
// releases channels in ascending order; faults and sw requests re-sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_pll_locked,
  input  logic                   i_ext_rst_n,
  input  logic                   i_sw_rst,
  output logic [NUM_CH-1:0]      o_rst_out,
  output logic                   o_all_released,
  output logic                   o_seq_busy,
  output logic [FAULT_CNT_W-1:0] o_fault_cnt
);

  generate
    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_ch
      $error("reset_sequencer: NUM_CH out of range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("reset_sequencer: SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < FILT_MIN) begin : g_bad_filt
      $error("reset_sequencer: FILT_CYCLES out of range");
    end
    if (HOLD_CYCLES < HOLD_MIN) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES out of range");
    end
    if (GAP_CYCLES < GAP_MIN) begin : g_bad_gap
      $error("reset_sequencer: GAP_CYCLES out of range");
    end
  endgenerate

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] BIT0 = NUM_CH'(1);

  logic w_lock_ok;
  logic w_ext_ok;
  logic w_cond_ok;
  logic w_fault;

  rst_sync_bit #(
    .STAGES     (SYNC_STAGES),
    .FILT_EN    (1'b1),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_sync_lock (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_async  (i_pll_locked),
    .o_level  (w_lock_ok)
  );

  rst_sync_bit #(
    .STAGES     (SYNC_STAGES),
    .FILT_EN    (1'b0),
    .FILT_CYCLES(1)
  ) u_sync_ext (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_async  (i_ext_rst_n),
    .o_level  (w_ext_ok)
  );

  seq_state_e             r_state;
  logic [NUM_CH-1:0]      r_rst_out;
  logic                   r_all_released;
  logic                   r_seq_busy;
  logic [FAULT_CNT_W-1:0] r_fault_cnt;
  logic [HW-1:0]          r_hold_cnt;
  logic [GW-1:0]          r_gap_cnt;
  logic [IW-1:0]          r_idx;

  assign w_cond_ok = w_lock_ok && w_ext_ok;
  assign w_fault   = (r_state != ST_ASSERT) && !w_cond_ok;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= ST_ASSERT;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
      r_seq_busy     <= 1'b0;
      r_fault_cnt    <= '0;
      r_hold_cnt     <= '0;
      r_gap_cnt      <= '0;
      r_idx          <= '0;
    end else if (w_fault || i_sw_rst) begin
      // Abort beats any release scheduled for this edge.
      r_state        <= ST_ASSERT;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
      r_seq_busy     <= 1'b0;
      r_hold_cnt     <= '0;
      r_gap_cnt      <= '0;
      r_idx          <= '0;
      if (w_fault && r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + 8'd1;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_rst_out <= '1;
          if (w_cond_ok) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_seq_busy <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            r_rst_out <= r_rst_out & ~BIT0;
            if (NUM_CH == 1) begin
              r_state        <= ST_RUN;
              r_all_released <= 1'b1;
              r_seq_busy     <= 1'b0;
            end else begin
              r_state   <= ST_RELEASE;
              r_gap_cnt <= '0;
              r_idx     <= IW'(1);
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            r_gap_cnt <= '0;
            r_rst_out <= r_rst_out & ~(BIT0 << r_idx);
            if (r_idx == IW'(NUM_CH - 1)) begin
              r_state        <= ST_RUN;
              r_all_released <= 1'b1;
              r_seq_busy     <= 1'b0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        ST_RUN: begin
          r_seq_busy <= 1'b0;
        end
        default: begin
          r_state   <= ST_ASSERT;
          r_rst_out <= '1;
        end
      endcase
    end
  end

  assign o_rst_out      = r_rst_out;
  assign o_all_released = r_all_released;
  assign o_seq_busy     = r_seq_busy;
  assign o_fault_cnt    = r_fault_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected output snapshots are queued against cycle numbers.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, ext_rst_n, sw_rst;
  logic [2:0] rst0;
  logic       all0, busy0;
  logic [7:0] fc0;
  logic [0:0] rst1;
  logic       all1, busy1;
  logic [7:0] fc1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    bit          dut;
    logic [12:0] val;
    string       tag;
  } sb_t;
  sb_t sb[$];

  reset_sequencer u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_pll_locked(pll_locked),
    .i_ext_rst_n(ext_rst_n), .i_sw_rst(sw_rst),
    .o_rst_out(rst0), .o_all_released(all0), .o_seq_busy(busy0), .o_fault_cnt(fc0)
  );

  reset_sequencer #(.NUM_CH(1), .GAP_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .i_pll_locked(pll_locked),
    .i_ext_rst_n(ext_rst_n), .i_sw_rst(sw_rst),
    .o_rst_out(rst1), .o_all_released(all1), .o_seq_busy(busy1), .o_fault_cnt(fc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Value layout: {rst_out[2:0], all_released, seq_busy, fault_cnt[7:0]}
  task automatic exp_at(input string tag, input int c, input bit d,
                        input logic [2:0] r, input logic a, input logic b,
                        input logic [7:0] f);
    sb_t e;
    e.cyc = c; e.dut = d; e.val = {r, a, b, f}; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    logic [12:0] obs;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      obs = e.dut ? {2'b00, rst1, all1, busy1, fc1} : {rst0, all0, busy0, fc0};
      chk(e.tag, obs, e.val);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s, f, g, h, r;
    reset_n = 1'b0; pll_locked = 1'b0; ext_rst_n = 1'b1; sw_rst = 1'b0;
    exp_at("reset0", 2, 0, 3'b111, 0, 0, 8'd0);
    exp_at("reset1", 2, 1, 3'b001, 0, 0, 8'd0);
    tick(3);

    // power-up sequence
    reset_n = 1'b1; pll_locked = 1'b1; e0 = cyc + 1;
    exp_at("pre_hold",   e0 + 9,  0, 3'b111, 0, 0, 8'd0);
    exp_at("hold_entry", e0 + 10, 0, 3'b111, 0, 1, 8'd0);
    exp_at("hold_end",   e0 + 25, 0, 3'b111, 0, 1, 8'd0);
    exp_at("hold_end1",  e0 + 25, 1, 3'b001, 0, 1, 8'd0);
    exp_at("rel0",       e0 + 26, 0, 3'b110, 0, 1, 8'd0);
    exp_at("ch1_run",    e0 + 26, 1, 3'b000, 1, 0, 8'd0);
    exp_at("gap0",       e0 + 29, 0, 3'b110, 0, 1, 8'd0);
    exp_at("rel1",       e0 + 30, 0, 3'b100, 0, 1, 8'd0);
    exp_at("gap1",       e0 + 33, 0, 3'b100, 0, 1, 8'd0);
    exp_at("rel2",       e0 + 34, 0, 3'b000, 1, 0, 8'd0);
    tick(e0 + 36 - cyc);

    // software re-sequence from RUN
    sw_rst = 1'b1; s = cyc + 1;
    exp_at("sw_assert",  s,      0, 3'b111, 0, 0, 8'd0);
    exp_at("sw_assert1", s,      1, 3'b001, 0, 0, 8'd0);
    exp_at("sw_hold",    s + 1,  0, 3'b111, 0, 1, 8'd0);
    exp_at("sw_pre_rel", s + 16, 0, 3'b111, 0, 1, 8'd0);
    exp_at("sw_rel0",    s + 17, 0, 3'b110, 0, 1, 8'd0);
    exp_at("sw_rel0_1",  s + 17, 1, 3'b000, 1, 0, 8'd0);
    tick(1);
    sw_rst = 1'b0;
    tick(s + 18 - cyc);

    // one-cycle lock loss in RELEASE, colliding with the bit-1 release
    pll_locked = 1'b0; f = cyc + 1;
    exp_at("drop_pre",   f + 1,  0, 3'b110, 0, 1, 8'd0);
    exp_at("drop_fault", f + 2,  0, 3'b111, 0, 0, 8'd1);
    exp_at("drop_fault1",f + 2,  1, 3'b001, 0, 0, 8'd1);
    exp_at("rec_hold",   f + 26, 0, 3'b111, 0, 1, 8'd1);
    exp_at("rec_rel0",   f + 27, 0, 3'b110, 0, 1, 8'd1);
    exp_at("rec_rel0_1", f + 27, 1, 3'b000, 1, 0, 8'd1);
    exp_at("rec_rel1",   f + 31, 0, 3'b100, 0, 1, 8'd1);
    exp_at("rec_run",    f + 35, 0, 3'b000, 1, 0, 8'd1);
    tick(1);
    pll_locked = 1'b1;
    tick(f + 36 - cyc);

    // lock lost, then a short glitch that must not qualify
    pll_locked = 1'b0; g = cyc + 1;
    exp_at("loss",  g + 2, 0, 3'b111, 0, 0, 8'd2);
    exp_at("loss1", g + 2, 1, 3'b001, 0, 0, 8'd2);
    tick(12);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    for (int k = 1; k <= 6; k++)
      exp_at("glitch", cyc + 5 * k, 0, 3'b111, 0, 0, 8'd2);
    tick(32);

    // block reset pulse in the middle of HOLD
    pll_locked = 1'b1; h = cyc;
    exp_at("h_hold", h + 11, 0, 3'b111, 0, 1, 8'd2);
    tick(15);
    reset_n = 1'b0; r = cyc + 1;
    exp_at("mid_rst",   r,      0, 3'b111, 0, 0, 8'd0);
    exp_at("mid_rst1",  r,      1, 3'b001, 0, 0, 8'd0);
    exp_at("rs_hold",   r + 26, 0, 3'b111, 0, 1, 8'd0);
    exp_at("rs_rel0",   r + 27, 0, 3'b110, 0, 1, 8'd0);
    exp_at("rs_rel0_1", r + 27, 1, 3'b000, 1, 0, 8'd0);
    exp_at("rs_run",    r + 35, 0, 3'b000, 1, 0, 8'd0);
    tick(1);
    reset_n = 1'b1;
    tick(r + 37 - cyc);

    chk("sb_drain", 13'(sb.size()), 13'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3, number of reset output channels (1..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop count per asynchronous input (2..4).
REQ-003 Parameter FILT_CYCLES, default 8, consecutive synchronised-high cycles of pll_locked before lock is accepted (>=1).
REQ-004 Parameter HOLD_CYCLES, default 16, minimum all-asserted hold once conditions are good (>=1).
REQ-005 Parameter GAP_CYCLES, default 4, spacing between successive channel releases (>=1).
REQ-006 clk  in  1  single clock; every flop in the block is clocked by its rising edge.
REQ-007 reset_n  in  1  synchronous, active-low block reset.
REQ-008 pll_locked  in  1  asynchronous clock-source lock indication, high = locked.
REQ-009 ext_rst_n  in  1  asynchronous external reset request, active-low.
REQ-010 sw_rst  in  1  synchronous single-cycle software re-sequence request, active-high.
REQ-011 rst_out  out  NUM_CH  per-channel reset, active-high; bit 0 releases first.
REQ-012 all_released  out  1  high only when every rst_out bit is low.
REQ-013 seq_busy  out  1  high in HOLD and RELEASE states.
REQ-014 fault_cnt  out  8  saturating count of fault-initiated re-sequences.

Function
REQ-015 Each asynchronous input SHALL pass through a SYNC_STAGES-deep flop chain before any use.
REQ-016 lock_ok SHALL rise when synchronised pll_locked has been high FILT_CYCLES consecutive cycles, and SHALL fall in the same cycle the synchronised value is low.
REQ-017 cond_ok SHALL equal lock_ok AND synchronised ext_rst_n.
REQ-018 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN.
REQ-019 ASSERT: rst_out all ones; if cond_ok, next state HOLD with hold counter cleared.
REQ-020 HOLD: counter increments each cycle; at count HOLD_CYCLES-1 the next state SHALL be RELEASE with rst_out[0] cleared on that same edge.
REQ-021 RELEASE: every GAP_CYCLES cycles the next-higher rst_out bit SHALL clear; the edge clearing bit NUM_CH-1 SHALL enter RUN and set all_released.
REQ-022 Release order SHALL be strictly ascending; no output SHALL reassert except via a return to ASSERT.
REQ-023 With NUM_CH=1, RELEASE SHALL be skipped: HOLD completion goes directly to RUN.
REQ-024 Fault (cond_ok low) in HOLD, RELEASE or RUN SHALL set rst_out all ones and enter ASSERT on the next edge, and SHALL increment fault_cnt, saturating at 255.
REQ-025 sw_rst in any state SHALL behave as a fault, except that fault_cnt is not incremented.
REQ-026 A fault or sw_rst in the same cycle as a scheduled release SHALL take priority; that channel stays asserted.
REQ-027 Hold and gap counters SHALL be $clog2(max+1) bits wide, and SHALL never wrap.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 reset_n low at an edge SHALL produce: rst_out all ones, all_released 0, seq_busy 0, fault_cnt 0, state ASSERT, counters 0, synchroniser and filter flops 0. This applies mid-sequence and overrides every other event.
REQ-030 After reset_n rises, sequencing SHALL restart from ASSERT using freshly synchronised inputs.

Structure
REQ-031 Package reset_seq_pkg SHALL hold the state enumeration and the parameter legality bounds.
REQ-032 Sub-module rst_sync_bit SHALL implement one synchroniser chain with an optional high-level filter. It SHALL be instantiated for pll_locked with filter and for ext_rst_n without filter.
REQ-033 Illegal parameter values SHALL cause an elaboration-time error.

Verification (defaults unless stated)
REQ-034 Power-up: ext_rst_n=1, pll_locked rises, sampled at edge E0 -> rst_out[0] falls at E0+26, rst_out[1] at E0+30, rst_out[2] and all_released at E0+34.
REQ-035 pll_locked drops for 1 cycle in RELEASE after rst_out[0] is cleared -> all rst_out high 3 edges later, fault_cnt=1. After the input recovers, the full 26-cycle sequence repeats.
REQ-036 pll_locked glitches high for 5 cycles (less than FILT_CYCLES) -> HOLD is never entered and rst_out stays 3'b111.
REQ-037 sw_rst pulse in RUN -> rst_out 3'b111 at the next edge, fault_cnt unchanged, rst_out[0] falls 17 edges after the sw_rst sample.
REQ-038 reset_n held low 1 cycle mid-HOLD -> all outputs at reset values next edge; the sequence restarts and takes SYNC_STAGES+FILT+HOLD cycles.
REQ-039 NUM_CH=1, GAP_CYCLES=1 -> rst_out and all_released change together, at E0+26.
